register_arbiter: RTL and testbench
===================================

REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, 4, width of the shared register and of each requester data lane.
REQ-003 Parameter HOLD, 2, cycles the register is held after a write before re-arbitration (0..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port req, input, N_REQ: per-requester write request, level, held until the matching ack.
REQ-008 Port data, input, N_REQ*WIDTH: lane i is bits [i*WIDTH +: WIDTH], stable while req[i] is high.
REQ-009 Port q, output, WIDTH: shared register contents.
REQ-010 Port ack, output, N_REQ: one-hot write-done pulse, registered.
REQ-011 Port owner, output, clog2(N_REQ): index of the last requester written, registered.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WRITE and HOLD.
REQ-014 IDLE, req nonzero at an edge: latch the round-robin winner into gnt_idx; go to WRITE. IDLE, req zero: stay in IDLE.
REQ-015 The round-robin search SHALL start at ptr and wrap modulo N_REQ; the first set req bit wins.
REQ-016 WRITE, req[gnt_idx] high at the edge, all of the following SHALL occur:
  - q <= data lane gnt_idx.
  - ack <= one-hot(gnt_idx).
  - owner <= gnt_idx.
  - ptr <= (gnt_idx+1) mod N_REQ.
  - Next state: HOLD if HOLD>0, else IDLE.
REQ-017 WRITE, req[gnt_idx] low at the edge (withdrawal), the block SHALL abort:
  - q, owner, ptr and ack unchanged.
  - Next state: IDLE.
REQ-018 ack SHALL be high for exactly one cycle, coincident with the first cycle q shows the new value, and low otherwise.
REQ-019 HOLD SHALL last exactly HOLD cycles, then return to IDLE; req SHALL be ignored in HOLD.
REQ-020 Latency from req sampled in IDLE to q updated SHALL be 2 edges; grant period SHALL be 2+HOLD cycles.
REQ-021 A req still high when IDLE is re-entered SHALL be treated as a new request; requesters drop req on seeing ack.
REQ-022 A req that rises during WRITE or HOLD SHALL be considered only at the next IDLE edge.

Reset
REQ-023 While rst is low, all outputs SHALL be forced immediately, independent of clk:
  - q=0, ack=0, owner=0, busy=0.
  - FSM in IDLE, ptr=0, hold counter=0.
REQ-024 Reset asserted in WRITE or HOLD SHALL abort the transfer: no ack, q cleared.
REQ-025 The first arbitration SHALL occur at the first rising edge with rst high.

Structure
REQ-026 State encodings and default parameter constants SHALL live in shared package register_arbiter_pkg.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs grant index and valid.

Verification (N_REQ=4, WIDTH=4, HOLD=2)
REQ-028 Reset: rst low with req=4'hF, data all 4'hF. Required: q=0, ack=0, busy=0; after release, first ack is ack=4'b0001.
REQ-029 Single request: req=4'b0100, lane2=4'hA. Required: after the second edge, q=4'hA, ack=4'b0100 for one cycle, owner=2, busy high for 3 cycles.
REQ-030 Full load: req=4'hF, lanes 1,2,3,4, each req held until its own ack. Required: q sequence 1,2,3,4; acks 0,1,2,3, spaced 4 cycles apart.
REQ-031 Fairness: after a grant to requester 2, apply req=4'b0101. Required: grant 0 first, then 2.
REQ-032 Withdrawal: req=4'b0010, drop req[1] in WRITE. Required: no ack, q unchanged, busy low next cycle, ptr unchanged.
REQ-033 Reset in HOLD: assert rst one cycle after ack. Required: q=0 and busy=0 immediately; no further ack.

Source files
------------

// File: rtl/register_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// register_arbiter_pkg
// Shared definitions for the register arbiter:
//   - default parameter values (requester count, lane width, hold length)
//   - width of the hold counter
//   - FSM state encoding
//   - wrap_inc helper used for the round-robin pointer update
// -----------------------------------------------------------------------------
package register_arbiter_pkg;

   localparam int unsigned DefNReq  = 4;
   localparam int unsigned DefWidth = 4;
   localparam int unsigned DefHold  = 2;

   // Large enough for the maximum hold length of 15.
   localparam int unsigned HoldCntW = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StHold  = 2'd2
   } state_e;

   // Increment an index and wrap it back to zero at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/register_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// register_arbiter_rr_pick (module rr_pick)
// Combinational round-robin selector. The search starts at i_ptr, wraps
// modulo N_REQ, and the first set request bit wins.
//
// Ports:
//   i_req     [N_REQ-1:0]  request vector
//   i_ptr     [IDX_W-1:0]  highest-priority index; must be < N_REQ
//   o_gnt_idx [IDX_W-1:0]  index of the winning requester ('0 when none)
//   o_valid                at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_valid
);

   int               w_sum;
   logic [IDX_W-1:0] w_cand;

   // Walk the offsets from farthest to nearest so the candidate closest to
   // i_ptr is the last one written and therefore the one that wins.
   always_comb begin
      o_valid   = 1'b0;
      o_gnt_idx = '0;
      w_sum     = 0;
      w_cand    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_sum = int'(i_ptr) + k;
         if (w_sum >= int'(N_REQ)) begin
            w_sum = w_sum - int'(N_REQ);
         end
         w_cand = IDX_W'(w_sum);
         if (i_req[w_cand]) begin
            o_valid   = 1'b1;
            o_gnt_idx = w_cand;
         end
      end
   end

endmodule

// File: rtl/register_arbiter.sv
// -----------------------------------------------------------------------------
// register_arbiter
// Shares one WIDTH-bit register among N_REQ requesters. An idle edge with any
// request latches the round-robin winner. The next edge writes that winner's
// data lane into q, provided the winner still requests, and pulses ack. The
// register is then held for HOLD cycles before the next arbitration. A
// requester that withdraws during WRITE aborts the transfer without
// side effects.
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    asynchronous active-low reset
//   req   [N_REQ-1:0]      level write requests, held until ack
//   data  [N_REQ*WIDTH-1:0] lane i at [i*WIDTH +: WIDTH]
//   q     [WIDTH-1:0]      shared register contents
//   ack   [N_REQ-1:0]      one-hot single-cycle write-done pulse
//   owner [clog2(N_REQ)-1:0] index of the last requester written
//   busy                   high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module register_arbiter
   import register_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned HOLD  = DefHold
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WIDTH-1:0]     data,
   output logic [WIDTH-1:0]           q,
   output logic [N_REQ-1:0]           ack,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   // Counter value loaded on entering HOLD; HOLD reaches zero after HOLD cycles.
   localparam logic [HoldCntW-1:0] HoldLast = (HOLD > 0) ? HoldCntW'(HOLD - 1) : '0;

   state_e              r_state;
   state_e              w_state_next;
   logic [IdxW-1:0]     r_gnt_idx;
   logic [IdxW-1:0]     w_gnt_idx_next;
   logic [IdxW-1:0]     r_ptr;
   logic [IdxW-1:0]     w_ptr_next;
   logic [HoldCntW-1:0] r_hold_cnt;
   logic [HoldCntW-1:0] w_hold_cnt_next;
   logic [WIDTH-1:0]    r_q;
   logic [WIDTH-1:0]    w_q_next;
   logic [N_REQ-1:0]    r_ack;
   logic [N_REQ-1:0]    w_ack_next;
   logic [IdxW-1:0]     r_owner;
   logic [IdxW-1:0]     w_owner_next;

   logic [IdxW-1:0]     w_pick_idx;
   logic                w_pick_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IdxW)
   ) u_rr_pick (
      .i_req     (req),
      .i_ptr     (r_ptr),
      .o_gnt_idx (w_pick_idx),
      .o_valid   (w_pick_valid)
   );

   // State and output registers. Every output is reset asynchronously, so a
   // reset in WRITE or HOLD drops the transfer and clears q at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_gnt_idx  <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_q        <= '0;
         r_ack      <= '0;
         r_owner    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_gnt_idx  <= w_gnt_idx_next;
         r_ptr      <= w_ptr_next;
         r_hold_cnt <= w_hold_cnt_next;
         r_q        <= w_q_next;
         r_ack      <= w_ack_next;
         r_owner    <= w_owner_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_gnt_idx_next  = r_gnt_idx;
      w_ptr_next      = r_ptr;
      w_hold_cnt_next = r_hold_cnt;
      w_q_next        = r_q;
      w_ack_next      = '0;
      w_owner_next    = r_owner;

      unique case (r_state)
         StIdle: begin
            if (w_pick_valid) begin
               w_gnt_idx_next = w_pick_idx;
               w_state_next   = StWrite;
            end
         end

         StWrite: begin
            // Only commit if the winner is still requesting. Otherwise treat
            // the request as withdrawn and leave all visible state alone.
            if (req[r_gnt_idx]) begin
               w_q_next              = data[int'(r_gnt_idx)*WIDTH +: WIDTH];
               w_ack_next[r_gnt_idx] = 1'b1;
               w_owner_next          = r_gnt_idx;
               w_ptr_next            = IdxW'(wrap_inc(32'(r_gnt_idx), N_REQ));
               if (HOLD > 0) begin
                  w_hold_cnt_next = HoldLast;
                  w_state_next    = StHold;
               end else begin
                  w_state_next = StIdle;
               end
            end else begin
               w_state_next = StIdle;
            end
         end

         StHold: begin
            // Requests are ignored here; they are sampled again in StIdle.
            if (r_hold_cnt == '0) begin
               w_state_next = StIdle;
            end else begin
               w_hold_cnt_next = r_hold_cnt - 1'b1;
            end
         end

         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   assign q     = r_q;
   assign ack   = r_ack;
   assign owner = r_owner;
   assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_register_arbiter.sv
module tb_register_arbiter;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int HLD = 2;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*W-1:0] data;
   logic [W-1:0]  q;
   logic [N-1:0]  ack;
   logic [1:0]    owner;
   logic          busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   register_arbiter #(
      .N_REQ (N),
      .WIDTH (W),
      .HOLD  (HLD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data  (data),
      .q     (q),
      .ack   (ack),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: the transfer is described as a number of busy cycles
   // remaining, with the write taking place on the first of them.
   // ---------------------------------------------------------------------------
   logic [W-1:0] m_q;
   logic [N-1:0] m_ack;
   int           m_owner;
   int           m_ptr;
   int           m_left;
   int           m_gnt;
   bit           m_wr;
   int           m_win;

   function automatic int rr_win(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always_comb m_win = rr_win(req, m_ptr);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q     <= '0;
         m_ack   <= '0;
         m_owner <= 0;
         m_ptr   <= 0;
         m_left  <= 0;
         m_gnt   <= 0;
         m_wr    <= 1'b0;
      end else begin
         m_ack <= '0;
         if (m_left == 0) begin
            if (m_win >= 0) begin
               m_gnt  <= m_win;
               m_left <= 1 + HLD;
               m_wr   <= 1'b1;
            end
         end else if (m_wr) begin
            m_wr <= 1'b0;
            if (req[m_gnt]) begin
               m_q     <= data[m_gnt*W +: W];
               m_ack   <= 4'b0001 << m_gnt;
               m_owner <= m_gnt;
               m_ptr   <= (m_gnt + 1) % N;
               m_left  <= HLD;
            end else begin
               m_left <= 0;
            end
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      check("q_vs_model",     32'(q),     32'(m_q));
      check("ack_vs_model",   32'(ack),   32'(m_ack));
      check("owner_vs_model", 32'(owner), 32'(m_owner));
      check("busy_vs_model",  32'(busy),  32'(m_left != 0));
   end

   // ---------------------------------------------------------------------------
   // Directed helpers; all are entered and left just after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic wait_ack(input string name, output logic [N-1:0] got, output int at);
      bit done = 1'b0;
      got = '0;
      at  = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk);
         #1;
         if (ack != '0) begin
            got  = ack;
            at   = cyc;
            done = 1'b1;
         end
      end
      if (!done) check({name, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (!busy) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) check({name, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic [N-1:0] got;
   int           at;
   int           prev_at;
   int           busy_cycles;
   int           ack_seen;

   initial begin
      // Reset with every requester active and all lanes at F.
      rst  = 1'b0;
      req  = 4'hF;
      data = 16'hFFFF;
      #2;
      check("rst_q",    32'(q),    32'h0);
      check("rst_ack",  32'(ack),  32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      wait_ack("rst_first", got, at);
      check("rst_first_ack", 32'(got), 32'b0001);
      req = '0;
      wait_idle("rst_first");

      // Full load from pointer 0: lanes hold 1,2,3,4.
      do_reset();
      data = 16'h4321;
      req  = 4'hF;
      prev_at = 0;
      for (int k = 0; k < N; k++) begin
         wait_ack("full", got, at);
         check("full_ack",   32'(got),   32'(4'b0001 << k));
         check("full_q",     32'(q),     32'(k + 1));
         check("full_owner", 32'(owner), 32'(k));
         if (k > 0) check("full_spacing", 32'(at - prev_at), 32'd4);
         prev_at = at;
         req = req & ~got;
      end
      wait_idle("full");

      // Single request from requester 2 with lane 2 = A.
      data = 16'h0A00;
      req  = 4'b0100;
      busy_cycles = 0;
      @(posedge clk); #1;
      check("single_busy_write", 32'(busy), 32'h1);
      check("single_no_ack",     32'(ack),  32'h0);
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      check("single_q",     32'(q),     32'hA);
      check("single_ack",   32'(ack),   32'b0100);
      check("single_owner", 32'(owner), 32'd2);
      if (busy) busy_cycles++;
      req = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (busy) busy_cycles++;
         if (i == 0) check("single_ack_gone", 32'(ack), 32'h0);
      end
      check("single_busy_len", 32'(busy_cycles), 32'd3);

      // Fairness: pointer is 3 after granting 2, so 0 goes before 2.
      data = 16'h0705;
      req  = 4'b0101;
      wait_ack("fair0", got, at);
      check("fair_first",  32'(got), 32'b0001);
      check("fair_first_q", 32'(q),  32'h5);
      req = req & ~got;
      wait_ack("fair1", got, at);
      check("fair_second",   32'(got), 32'b0100);
      check("fair_second_q", 32'(q),   32'h7);
      req = req & ~got;
      wait_idle("fair");

      // Withdrawal of requester 1 while in WRITE.
      data = 16'h0795;
      req  = 4'b0010;
      @(posedge clk); #1;
      check("wd_busy_write", 32'(busy), 32'h1);
      req = '0;
      @(posedge clk); #1;
      check("wd_busy_low", 32'(busy),  32'h0);
      check("wd_no_ack",   32'(ack),   32'h0);
      check("wd_q_kept",   32'(q),     32'h7);
      check("wd_owner",    32'(owner), 32'd2);
      // Pointer must still be 3, so requester 0 beats requester 2.
      req = 4'b0101;
      wait_ack("wd_ptr", got, at);
      check("wd_ptr_kept", 32'(got), 32'b0001);
      req = req & ~got;
      wait_ack("wd_rest", got, at);
      check("wd_rest_ack", 32'(got), 32'b0100);
      req = req & ~got;
      wait_idle("wd");

      // Reset one cycle after ack, inside HOLD.
      data = 16'hC795;
      req  = 4'b1000;
      wait_ack("rh", got, at);
      check("rh_ack", 32'(got), 32'b1000);
      check("rh_q",   32'(q),   32'hC);
      req = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rh_q_clr",    32'(q),    32'h0);
      check("rh_busy_clr", 32'(busy), 32'h0);
      check("rh_ack_clr",  32'(ack),  32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      ack_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack != '0) ack_seen++;
      end
      check("rh_no_more_ack", 32'(ack_seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
